// File: rtl/mux8x1_rr_arbiter.sv
// mux8x1_rr_arbiter: round-robin owner arbitration with registered one-hot grant and 8:1 mux select
module mux8x1_rr_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] sel,
  output logic       valid,
  output logic       expired
);
  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;
  localparam int CW = ($clog2(MAX_HOLD + 1) < 1) ? 1 : $clog2(MAX_HOLD + 1);
  state_t state, state_n;
  logic [2:0] ptr, ptr_n, win, sel_n;
  logic [7:0] gnt_n;
  logic [CW-1:0] cnt, cnt_n;
  logic valid_n, expired_n, tmo, rel;
  always_comb begin
    win = ptr;
    for (int i = 7; i >= 0; i--)
      if (req[ptr + 3'(i)]) win = ptr + 3'(i);
  end
  assign tmo = (MAX_HOLD != 0) && (cnt == CW'(MAX_HOLD));
  assign rel = done || !req[sel] || tmo;
  always_comb begin
    state_n   = state;
    gnt_n     = gnt;
    sel_n     = sel;
    valid_n   = valid;
    expired_n = 1'b0;
    ptr_n     = ptr;
    cnt_n     = cnt;
    if (state == BUSY) begin
      if (rel) begin
        state_n   = GAP;
        gnt_n     = '0;
        valid_n   = 1'b0;
        expired_n = tmo && !done && req[sel];
        cnt_n     = '0;
      end else begin
        cnt_n = (cnt == '1) ? cnt : cnt + CW'(1);
      end
    end else if (|req) begin
      state_n = BUSY;
      gnt_n   = 8'b1 << win;
      sel_n   = win;
      valid_n = 1'b1;
      ptr_n   = win + 3'd1;
      cnt_n   = CW'(1);
    end else begin
      state_n = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      gnt     <= '0;
      sel     <= '0;
      valid   <= 1'b0;
      expired <= 1'b0;
      ptr     <= '0;
      cnt     <= '0;
    end else begin
      state   <= state_n;
      gnt     <= gnt_n;
      sel     <= sel_n;
      valid   <= valid_n;
      expired <= expired_n;
      ptr     <= ptr_n;
      cnt     <= cnt_n;
    end
  end
endmodule
